// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and lane/alignment helpers for the core memory-access unit
// Contents:
//   size_e      access size (byte, half, word, dword)
//   state_e     bus master FSM states
//   err_e       response error codes
//   lane_mask   contiguous byte-enable mask for a size at a byte offset (8 lanes wide)
//   misaligned  natural-alignment check on the low three address bits
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BUS   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_SIZE     = 2'd3
    } err_e;

    // Always 8 lanes wide; narrower buses keep the low LANES bits.
    function automatic logic [7:0] lane_mask(input size_e size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [2:0] addr);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr[0];
            SZ_WORD: return |addr[1:0];
            default: return |addr[2:0];
        endcase
    endfunction

endpackage

// File: rtl/mips_bus_master_if.sv
// rtl/mips_bus_master_if.sv - Avalon-MM style master bus bundle
// Signals:
//   address     byte address, aligned to the bus width (master -> slave)
//   read/write  transfer strobes, never high together (master -> slave)
//   writedata   lane-replicated store data (master -> slave)
//   byteenable  active byte lanes (master -> slave)
//   waitrequest slave stall (slave -> master)
//   readdata    load data, valid while read is high and waitrequest is low (slave -> master)
interface mips_bus_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [LANES-1:0]  byteenable;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_load_align.sv
// rtl/mips_load_align.sv - selects the addressed lanes of bus read data and sign/zero extends them
// Ports:
//   readdata  in   DATA_W  raw bus read data
//   offset    in   OFF_W   byte offset of the access within the bus word
//   size      in   size_e  access size
//   sgn       in   1       1 = sign-extend, 0 = zero-extend
//   extended  out  DATA_W  right-justified, extended load result
module mips_load_align
    import mips_bus_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]                 readdata,
    input  logic [$clog2(DATA_W/8)-1:0]       offset,
    input  size_e                             size,
    input  logic                              sgn,
    output logic [DATA_W-1:0]                 extended
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] keep;
    logic              sign_bit;

    always_comb begin
        shifted  = readdata >> {offset, 3'b000};
        keep     = '1;
        sign_bit = shifted[DATA_W-1];
        case (size)
            SZ_BYTE: begin
                keep     = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            SZ_HALF: begin
                keep     = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_WORD: begin
                keep     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                keep     = '1;
                sign_bit = shifted[DATA_W-1];
            end
        endcase
        // Bits above the access width are either cleared or filled with the sign.
        extended = (shifted & keep) | ((sgn && sign_bit) ? ~keep : '0);
    end

endmodule

// File: rtl/mips_bus_master.sv
// rtl/mips_bus_master.sv - single-outstanding load/store unit between the core and an Avalon-MM style bus
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     core request handshake; ready only while idle
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata               request fields, latched on acceptance
//   resp_valid              one-cycle completion pulse (never back-pressured)
//   resp_rdata, resp_error  extended load data / error code, valid with resp_valid
//   bus                     master side of mips_bus_master_if
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_error,
    mips_bus_master_if.master   bus
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    // The counter only has to reach TIMEOUT-1: the cycle that would make it
    // TIMEOUT is the one that aborts.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic                wr_q;
    size_e               size_q;
    logic                sgn_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    err_e                err_q;
    err_e                chk_err;
    logic                timeout_hit;
    logic [OFF_W-1:0]    offset;
    logic [LANES-1:0]    be_next;
    logic [DATA_W-1:0]   wdata_rep;
    logic [DATA_W-1:0]   load_data;

    assign offset  = addr_q[OFF_W-1:0];
    assign be_next = LANES'(lane_mask(size_q, 3'(offset)));

    // An unsupported size outranks alignment: the offset rules are meaningless for it.
    always_comb begin
        chk_err = ERR_OK;
        if (size_q == SZ_DWORD && DATA_W == 32) begin
            chk_err = ERR_SIZE;
        end else if (misaligned(size_q, addr_q[2:0])) begin
            chk_err = ERR_MISALIGN;
        end
    end

    // Replicate the low 2^size bytes of the store data across every lane so the
    // slave finds the data under whichever lanes byteenable selects.
    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < LANES; i++) begin
            case (size_q)
                SZ_BYTE: wdata_rep[8*i +: 8] = wdata_q[7:0];
                SZ_HALF: wdata_rep[8*i +: 8] = wdata_q[8*(i%2) +: 8];
                SZ_WORD: wdata_rep[8*i +: 8] = wdata_q[8*(i%4) +: 8];
                default: wdata_rep[8*i +: 8] = wdata_q[8*i +: 8];
            endcase
        end
    end

    // A slave that releases waitrequest in the aborting cycle still wins,
    // because the hit requires waitrequest to be high.
    assign timeout_hit = (TIMEOUT != 0) && bus.waitrequest &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));

    mips_load_align #(.DATA_W(DATA_W)) u_align (
        .readdata (bus.readdata),
        .offset   (offset),
        .size     (size_q),
        .sgn      (sgn_q),
        .extended (load_data)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = (chk_err != ERR_OK) ? ST_RESP : ST_BUS;
            end
            ST_BUS: begin
                if (!bus.waitrequest || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wr_q           <= 1'b0;
            size_q         <= SZ_BYTE;
            sgn_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            rdata_q        <= '0;
            err_q          <= ERR_OK;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 2'd0;
            bus.address    <= '0;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.writedata  <= '0;
            bus.byteenable <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        size_q  <= size_e'(req_size);
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                ST_CHECK: begin
                    err_q   <= chk_err;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                    if (chk_err == ERR_OK) begin
                        bus.address    <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus.byteenable <= be_next;
                        bus.writedata  <= wdata_rep;
                        bus.read       <= !wr_q;
                        bus.write      <= wr_q;
                    end
                end
                ST_BUS: begin
                    if (bus.waitrequest) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (!bus.waitrequest) begin
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        if (!wr_q) begin
                            rdata_q <= load_data;
                        end
                    end else if (timeout_hit) begin
                        bus.read  <= 1'b0;
                        bus.write <= 1'b0;
                        err_q     <= ERR_TIMEOUT;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= rdata_q;
                    resp_error <= err_q;
                    cnt_q      <= '0;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_master.sv
// tb/tb_mips_bus_master.sv - self-checking bench running a 32-bit (TIMEOUT 5) and a 64-bit (no timeout) unit side by side
module tb_mips_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        wait_r;
    logic [63:0] rd;

    logic        ready32, ready64, rv32, rv64;
    logic [31:0] rdata32;
    logic [63:0] rdata64;
    logic [1:0]  err32, err64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_bus_master_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    mips_bus_master_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    assign bus32.waitrequest = wait_r;
    assign bus32.readdata    = rd[31:0];
    assign bus64.waitrequest = wait_r;
    assign bus64.readdata    = rd;

    mips_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(5)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(ready32), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .resp_valid(rv32), .resp_rdata(rdata32), .resp_error(err32),
        .bus(bus32)
    );

    mips_bus_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(ready64), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(rv64), .resp_rdata(rdata64), .resp_error(err64),
        .bus(bus64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Load result from first principles: pick nb bytes at byte offset off, then extend.
    function automatic logic [63:0] ext(input logic [63:0] data, input int off, input int nb,
                                        input bit sg, input int w);
        logic [63:0] v;
        logic [63:0] m;
        v = data >> (8 * off);
        m = (nb >= 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v = v & m;
        if (sg && nb < 8 && v[8*nb-1]) v = v | ~m;
        if (w == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic check_cycle_outputs(input int d, input int k, input bit wr, input int send,
                                       input int rc, input logic [63:0] ea, input logic [63:0] ebe,
                                       input logic [63:0] ewd, input logic [63:0] erd,
                                       input int err);
        string s;
        bit    strobe;
        logic  o_read, o_write, o_rv, o_ready;
        logic [63:0] o_addr, o_be, o_wd, o_rd;
        logic [1:0]  o_err;
        s       = d ? "64" : "32";
        o_read  = d ? bus64.read  : bus32.read;
        o_write = d ? bus64.write : bus32.write;
        o_addr  = d ? 64'(bus64.address)    : 64'(bus32.address);
        o_be    = d ? 64'(bus64.byteenable) : 64'(bus32.byteenable);
        o_wd    = d ? bus64.writedata       : 64'(bus32.writedata);
        o_rv    = d ? rv64 : rv32;
        o_rd    = d ? rdata64 : 64'(rdata32);
        o_err   = d ? err64 : err32;
        o_ready = d ? ready64 : ready32;
        strobe  = (k >= 1 && k <= send);
        chk($sformatf("read%s_c%0d", s, k),  64'(o_read),  64'(strobe && !wr));
        chk($sformatf("write%s_c%0d", s, k), 64'(o_write), 64'(strobe && wr));
        if (strobe) begin
            chk($sformatf("address%s_c%0d", s, k),    o_addr, ea);
            chk($sformatf("byteenable%s_c%0d", s, k), o_be,   ebe);
            if (wr) chk($sformatf("writedata%s_c%0d", s, k), o_wd, ewd);
        end
        chk($sformatf("resp_valid%s_c%0d", s, k), 64'(o_rv), 64'(k == rc));
        if (k == rc) begin
            chk($sformatf("resp_rdata%s", s), o_rd, erd);
            chk($sformatf("resp_error%s", s), 64'(o_err), 64'(err));
        end
        chk($sformatf("req_ready%s_c%0d", s, k), 64'(o_ready), 64'(k >= rc));
    endtask

    // One transaction on both units. waitrequest is high for the first n bus cycles.
    task automatic run(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [63:0] wd, input int n, input bit fix_rd,
                       input logic [63:0] rd_val);
        int nb, lanes, tmo, last;
        int err[2], send[2], rc[2], offs[2];
        logic [63:0] ea[2], ebe[2], ewd[2];
        logic [63:0] cap, erd;
        nb   = 1 << int'(sz);
        last = 0;
        cap  = '0;
        for (int d = 0; d < 2; d++) begin
            lanes   = d ? 8 : 4;
            tmo     = d ? 0 : 5;
            offs[d] = int'(a[2:0]) % lanes;
            if (sz == 2'd3 && lanes == 4)          err[d] = 3;
            else if ((int'(a[2:0]) % nb) != 0)     err[d] = 1;
            else if (tmo != 0 && n >= tmo)         err[d] = 2;
            else                                   err[d] = 0;
            case (err[d])
                0:       begin send[d] = n + 1; rc[d] = n + 3;   end
                2:       begin send[d] = tmo;   rc[d] = tmo + 2; end
                default: begin send[d] = 0;     rc[d] = 2;       end
            endcase
            ea[d]  = 64'(a) - 64'(offs[d]);
            ebe[d] = ((64'd1 << nb) - 64'd1) << offs[d];
            ewd[d] = '0;
            for (int i = 0; i < lanes; i++) ewd[d][8*i +: 8] = wd[8*(i % nb) +: 8];
            if (rc[d] + 1 > last) last = rc[d] + 1;
        end

        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            wait_r = (k >= 1 && k <= n);
            rd     = fix_rd ? rd_val : {$urandom, $urandom};
            if (k == n + 1) cap = rd;
            for (int d = 0; d < 2; d++) begin
                erd = (err[d] == 0 && !wr)
                      ? ext(d ? cap : (cap & 64'hFFFF_FFFF), offs[d], nb, sg, d ? 64 : 32)
                      : 64'd0;
                check_cycle_outputs(d, k, wr, send[d], rc[d], ea[d], ebe[d], ewd[d], erd, err[d]);
            end
        end
    endtask

    task automatic reset_mid_bus();
        req_write  = 1'b0;
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h40;
        req_wdata  = '0;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_r    = 1'b1;
        @(negedge clk);
        chk("rst_pre_read32", 64'(bus32.read), 64'd1);
        chk("rst_pre_read64", 64'(bus64.read), 64'd1);
        chk("rst_pre_ready32", 64'(ready32), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("rst_read32", 64'(bus32.read), 64'd0);
        chk("rst_read64", 64'(bus64.read), 64'd0);
        chk("rst_rv32", 64'(rv32), 64'd0);
        chk("rst_rv64", 64'(rv64), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        wait_r = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rv32_%0d", k), 64'(rv32), 64'd0);
            chk($sformatf("post_rst_rv64_%0d", k), 64'(rv64), 64'd0);
            chk($sformatf("post_rst_ready32_%0d", k), 64'(ready32), 64'd1);
            chk($sformatf("post_rst_ready64_%0d", k), 64'(ready64), 64'd1);
            chk($sformatf("post_rst_read64_%0d", k), 64'(bus64.read), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  r_sz;
        logic [31:0] r_a;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_signed = 1'b0;
        req_size   = 2'd0;
        req_addr   = '0;
        req_wdata  = '0;
        wait_r     = 1'b0;
        rd         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("reset_read32",  64'(bus32.read),  64'd0);
        chk("reset_write32", 64'(bus32.write), 64'd0);
        chk("reset_read64",  64'(bus64.read),  64'd0);
        chk("reset_write64", 64'(bus64.write), 64'd0);
        chk("reset_rv32",    64'(rv32),  64'd0);
        chk("reset_rv64",    64'(rv64),  64'd0);
        chk("reset_err32",   64'(err32), 64'd0);
        chk("reset_rdata64", rdata64,    64'd0);
        chk("reset_addr32",  64'(bus32.address),    64'd0);
        chk("reset_be64",    64'(bus64.byteenable), 64'd0);
        chk("reset_wd64",    bus64.writedata,       64'd0);
        chk("reset_ready32", 64'(ready32), 64'd1);
        reset = 1'b0;

        run(1'b0, 2'd0, 1'b1, 32'h103, 64'd0, 0, 1'b1, 64'h0000_0000_80FF_FF7F);
        run(1'b1, 2'd1, 1'b0, 32'h202, 64'h0000_BEEF, 3, 1'b0, 64'd0);
        run(1'b0, 2'd2, 1'b0, 32'h101, 64'd0, 0, 1'b0, 64'd0);
        run(1'b0, 2'd2, 1'b0, 32'h10, 64'd0, 5, 1'b0, 64'd0);
        run(1'b0, 2'd2, 1'b1, 32'h14, 64'd0, 4, 1'b0, 64'd0);
        run(1'b0, 2'd2, 1'b0, 32'h04, 64'd0, 0, 1'b1, 64'h8765_4321_0000_0000);
        run(1'b0, 2'd3, 1'b1, 32'h08, 64'd0, 1, 1'b0, 64'd0);
        run(1'b1, 2'd3, 1'b0, 32'h18, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 64'd0);
        run(1'b0, 2'd3, 1'b0, 32'h0C, 64'd0, 0, 1'b0, 64'd0);
        run(1'b1, 2'd0, 1'b0, 32'h07, 64'h0000_00A5, 2, 1'b0, 64'd0);

        for (int t = 0; t < 40; t++) begin
            r_sz = 2'($urandom_range(0, 3));
            r_a  = {21'd0, 8'($urandom_range(0, 255)), 3'b000};
            if ($urandom_range(0, 3) == 0) r_a[2:0] = 3'($urandom_range(1, 7));
            run(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_a,
                {$urandom, $urandom}, int'($urandom_range(0, 7)), 1'b0, 64'd0);
        end

        reset_mid_bus();
        run(1'b0, 2'd1, 1'b1, 32'h86, 64'd0, 1, 1'b0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_master.md
Name: mips_bus_master

Overview:
- Parametrised memory-access unit between the multicycle core's fetch/load/store control and an Avalon-MM style master bus (address, read, write, waitrequest, byteenable, writedata, readdata).
- Successor to the fixed 32-bit byte decoder, word mask and store replicator logic.
- Generalised to DATA_W of 32 or 64. Adds a core-side valid/ready request handshake, in-unit sign/zero extension, misalignment detection and a bus timeout.
- One outstanding transaction at a time.

Parameters:
- DATA_W, 32, bus/data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 0, maximum waitrequest-high cycles before abort; 0 disables the timeout.
- LANES, DATA_W/8, derived; number of byte lanes.
- OFF_W, log2(LANES), derived; number of byte-offset bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64).
- req_signed  in  1  sign-extend load result; 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle pulse; transaction complete.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_error  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
- address  out  ADDR_W  word-aligned bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- waitrequest  in  1  slave stall.
- writedata  out  DATA_W  lane-replicated store data.
- byteenable  out  LANES  active byte lanes.
- readdata  in  DATA_W  valid in the cycle waitrequest is low with read high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; read = write = 0; resp_valid = 0; resp_error = 0.
  - resp_rdata, address, writedata, byteenable = 0; timeout counter = 0.
  - Reset mid-transaction drops the strobes at once; no response is ever issued for the aborted request.
- States: IDLE, CHECK, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all req_* fields and go to CHECK.
- CHECK (one cycle, no bus activity):
  - Misaligned: addr[0] set for half, addr[1:0] nonzero for word, addr[2:0] nonzero for dword.
  - Illegal: size 3 when DATA_W = 32.
  - If misaligned or illegal, go to RESP with resp_error = 1 or 3.
  - Otherwise drive the bus outputs and go to BUS.
- Bus outputs (computed in CHECK, registered):
  - address = {addr[ADDR_W-1:OFF_W], 0}.
  - byteenable = contiguous mask of 2^size ones, shifted left by addr[OFF_W-1:0].
  - writedata = req_wdata low 2^size bytes replicated across all lanes.
- BUS:
  - read or write held high. address, byteenable and writedata held stable while waitrequest = 1.
  - When waitrequest = 0: capture the readdata lanes selected by the offset, extend to DATA_W per req_signed, deassert the strobes next edge, go to RESP with error 0.
  - Counter increments each cycle waitrequest = 1. If TIMEOUT != 0 and the counter reaches TIMEOUT, deassert the strobes, go to RESP with resp_error = 2 and rdata = 0.
  - waitrequest falling in the same cycle the counter reaches TIMEOUT counts as a success.
- RESP:
  - resp_valid = 1 for exactly one cycle; resp_rdata and resp_error valid in that cycle.
  - Then IDLE; counter cleared.
  - resp_valid is never back-pressured.
- Latency:
  - Aligned access, waitrequest low on the first BUS cycle: req accepted at edge 0, strobe high cycle 1 (CHECK to BUS), resp_valid cycle 3. Minimum 4 cycles per transaction.
  - Each waitrequest-high cycle adds 1.
- read and write are never high together.
- req_ready is 0 outside IDLE.

Decomposition:
- Package mips_bus_pkg holds:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), state_e and err_e enums.
  - Function lane_mask(size, offset).
  - Function misaligned(size, addr).
- Sub-module mips_load_align (combinational, parametrised by DATA_W): readdata, offset, size and signed in; extended data out.

Test Plan:
- DATA_W = 32, load byte signed at addr 0x103, readdata 0x80FF_FF7F, waitrequest = 0 -> address 0x100, byteenable 4'b1000, resp_rdata 0xFFFF_FF80, resp_error 0, resp_valid 3 cycles after acceptance.
- Store half 0x0000_BEEF at 0x202, waitrequest high 3 cycles -> address 0x200 held, byteenable 4'b1100, writedata 0xBEEF_BEEF stable throughout, write high 4 cycles, resp 6 cycles after acceptance.
- Load word at 0x101 -> no read strobe ever, resp_error 1, resp_rdata 0.
- TIMEOUT = 5, waitrequest stuck high -> read high exactly 5 cycles then 0, resp_error 2; next request accepted normally.
- DATA_W = 64, load word unsigned at 0x04, readdata 0x8765_4321_0000_0000 -> byteenable 8'hF0, resp_rdata 0x0000_0000_8765_4321. Size 3 with DATA_W = 32 -> resp_error 3.
- Assert reset during BUS with read high -> read 0 in the same cycle, no resp_valid, req_ready 1 after release.
